alu_op_sequencer: RTL

Control stage directly upstream of the 16-bit combinational ALU. Accepts register-level commands over a valid/ready handshake, holds operands in a 4-entry register file, and drives the ALU's A/B/carry-in/opcode inputs from registered operands. It captures the ALU result and both flags one cycle later, writes the result back, and presents it on a valid/ready response port. It turns the free-running combinational ALU into a sequenced, flow-controlled execution unit.

---
 rtl/alu_seq_pkg.sv | 24 ++
 rtl/alu_seq_regfile.sv | 48 ++++
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and default sizes for the ALU op sequencer:
//               FSM state encoding, datapath width, register file depth and
//               register address width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREG  = 4;
  localparam int REG_AW    = $clog2(DEF_NREG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_regfile.sv
// ============================================================================
// Module      : alu_seq_regfile
// Description : NREG x WIDTH register file with two combinational read ports
//               and one synchronous write port, cleared by synchronous reset.
// Revision    : 1.0 - initial release
// Ports       : clk, rst        - clock, synchronous active-high reset
//               we_i            - write enable
//               waddr_i/wdata_i - write address / data
//               raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o - read ports
// ============================================================================
`default_nettype none

module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Sequences register-level commands onto a combinational ALU.
//               Loads write the register file directly; ALU ops latch their
//               operands, give the ALU one EXEC cycle, write the result back
//               and present it on a valid/ready response port.
// Revision    : 1.0 - initial release
// Ports       : clk, rst                          - clock, sync active-high reset
//               cmd_valid_i/cmd_ready_o           - command handshake
//               cmd_ld_i, cmd_imm_i, cmd_opc_i    - load flag, immediate, opcode
//               cmd_rd_i, cmd_rs1_i, cmd_rs2_i    - register addresses
//               cmd_use_cf_i                      - carry-in from stored carry
//               alu_a_o, alu_b_o, alu_c_o, alu_opc_o - ALU operand drive
//               alu_w_i, alu_co_i, alu_zr_i       - ALU result and flags
//               res_valid_o/res_ready_i           - response handshake
//               res_data_o, res_co_o, res_zr_o    - captured result and flags
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_ld_i,
  input  logic [WIDTH-1:0]         cmd_imm_i,
  input  logic [2:0]               cmd_opc_i,
  input  logic [$clog2(NREG)-1:0]  cmd_rd_i,
  input  logic [$clog2(NREG)-1:0]  cmd_rs1_i,
  input  logic [$clog2(NREG)-1:0]  cmd_rs2_i,
  input  logic                     cmd_use_cf_i,
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  output logic                     alu_c_o,
  output logic [2:0]               alu_opc_o,
  input  logic [WIDTH-1:0]         alu_w_i,
  input  logic                     alu_co_i,
  input  logic                     alu_zr_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_data_o,
  output logic                     res_co_o,
  output logic                     res_zr_o
);

  localparam int AW = $clog2(NREG);

  state_t state_q, state_d;

  logic [WIDTH-1:0] opa_q, opb_q;
  logic             cin_q;
  logic [2:0]       opc_q;
  logic [AW-1:0]    rd_q;
  logic             cf_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_co_q, res_zr_q;

  logic             exec;
  logic             accept;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rf_rdata_a, rf_rdata_b;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    res_valid_o = 1'b0;
    exec        = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        // Loads complete in IDLE; only ALU ops leave it.
        if (cmd_valid_i && !cmd_ld_i) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = cmd_valid_i && cmd_ready_o;

  // ---------------------------------------------------------- register file
  // Loads only happen in IDLE and writeback only in EXEC, so one write port
  // suffices and the two sources never collide.
  assign rf_we    = (accept && cmd_ld_i) || exec;
  assign rf_waddr = exec ? rd_q    : cmd_rd_i;
  assign rf_wdata = exec ? alu_w_i : cmd_imm_i;

  alu_seq_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (cmd_rs1_i),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (cmd_rs2_i),
    .rdata_b_o (rf_rdata_b)
  );

  // ------------------------------------------------------ operand registers
  // Operands are sampled at accept, so rd aliasing rs1/rs2 is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
      cin_q <= 1'b0;
      opc_q <= '0;
      rd_q  <= '0;
    end else if (accept && !cmd_ld_i) begin
      opa_q <= rf_rdata_a;
      opb_q <= rf_rdata_b;
      cin_q <= cmd_use_cf_i ? cf_q : 1'b0;
      opc_q <= cmd_opc_i;
      rd_q  <= cmd_rd_i;
    end
  end

  // ------------------------------------------------ carry flag and response
  always_ff @(posedge clk) begin
    if (rst) begin
      cf_q       <= 1'b0;
      res_data_q <= '0;
      res_co_q   <= 1'b0;
      res_zr_q   <= 1'b0;
    end else if (exec) begin
      cf_q       <= alu_co_i;
      res_data_q <= alu_w_i;
      res_co_q   <= alu_co_i;
      res_zr_q   <= alu_zr_i;
    end
  end

  assign alu_a_o    = opa_q;
  assign alu_b_o    = opb_q;
  assign alu_c_o    = cin_q;
  assign alu_opc_o  = opc_q;
  assign res_data_o = res_data_q;
  assign res_co_o   = res_co_q;
  assign res_zr_o   = res_zr_q;

endmodule

`default_nettype wire
